// File: rtl/adj_scan_pkg.sv
// Shared minesweeper constants, scan FSM states and the 64-bit population count.
package adj_scan_pkg;

    localparam int unsigned BOARD_CELLS = 64;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned TOTAL_W     = 7;

    localparam logic [CNT_W-1:0] MINE_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    // One result beat on the write port.
    typedef struct packed {
        logic [IDX_W-1:0] addr;
        logic [CNT_W-1:0] data;
    } wr_beat_t;

    // Untruncated count of set bits in a full board word (0..64).
    function automatic logic [TOTAL_W-1:0] popcount64(input logic [BOARD_CELLS-1:0] v);
        logic [TOTAL_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(BOARD_CELLS); i++) begin
            n = n + TOTAL_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/adj_mask.sv
// Combinational neighbour mask: the up-to-8 cells around idx, clipped at the board edge.
module adj_mask
    import adj_scan_pkg::*;
#(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
) (
    input  logic [IDX_W-1:0]       idx,
    output logic [BOARD_CELLS-1:0] mask_c
);

    int row;
    int col;
    int r;
    int c;

    // Walk the 3x3 window; drop the centre and anything off the board (no wrap).
    always_comb begin
        mask_c = '0;
        row    = int'(idx[IDX_W-1:3]);
        col    = int'(idx[2:0]);
        r      = 0;
        c      = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = row + dr;
                c = col + dc;
                if (!(dr == 0 && dc == 0) &&
                    r >= 0 && r < int'(ROWS) &&
                    c >= 0 && c < int'(COLS)) begin
                    mask_c[IDX_W'(r * int'(COLS) + c)] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adj_scan.sv
// Minesweeper adjacency scanner: latches a 64-cell mine map and streams the
// neighbour-mine count of every cell, in index order, over a ready/valid port.
// Optional build macro ADJ_SCAN_MINE_MARK_EN: mine cells report MINE_CODE.
module adj_scan
    import adj_scan_pkg::*;
#(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [BOARD_CELLS-1:0] mine_map,
    output logic                   busy,
    output logic                   done,
    output logic                   wr_en,
    input  logic                   wr_ready,
    output logic [IDX_W-1:0]       wr_addr,
    output logic [CNT_W-1:0]       wr_data,
    output logic [TOTAL_W-1:0]     mine_total
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BOARD_CELLS - 1);

    scan_state_e            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BOARD_CELLS-1:0] map_q, map_d;
    logic [TOTAL_W-1:0]     total_q, total_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wr_en_q, wr_en_d;

    logic [BOARD_CELLS-1:0] mask_c;
    logic [CNT_W-1:0]       cnt_c;
    wr_beat_t               beat_c;

    adj_mask #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_adj_mask (
        .idx    (idx_q),
        .mask_c (mask_c)
    );

    // State, index, latched map and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            map_q   <= '0;
            total_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            map_q   <= map_d;
            total_q <= total_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_en_q <= wr_en_d;
        end
    end

    // Next-state logic: start latches the map, accepted beats advance the index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        map_d   = map_q;
        total_d = total_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wr_en_d = wr_en_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    map_d   = mine_map;
                    idx_d   = '0;
                    total_d = popcount64(mine_map);
                    state_d = ST_SCAN;
                    busy_d  = 1'b1;
                    wr_en_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    // Abort wins over a same-cycle acceptance, so no done pulse.
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    wr_en_d = 1'b0;
                end else if (wr_en_q && wr_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        wr_en_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    // Result beat is derived from the registered index, so it holds under back-pressure.
    always_comb begin
        cnt_c       = CNT_W'(popcount64(map_q & mask_c));
        beat_c.addr = idx_q;
`ifdef ADJ_SCAN_MINE_MARK_EN
        beat_c.data = map_q[idx_q] ? MINE_CODE : cnt_c;
`else
        beat_c.data = cnt_c;
`endif
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = beat_c.addr;
    assign wr_data    = beat_c.data;
    assign mine_total = total_q;

endmodule

// File: tb/tb_adj_scan.sv
// Directed bench for adj_scan with a scoreboard of expected write beats.
module tb_adj_scan;
    import adj_scan_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [63:0] mine_map;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic        wr_ready;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [6:0]  mine_total;

    int errors = 0;
    int checks = 0;

    wr_beat_t sb[$];

    adj_scan #(.ROWS(8), .COLS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mine_map   (mine_map),
        .busy       (busy),
        .done       (done),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mine_total (mine_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference count: scan every other cell and test Chebyshev distance 1.
    function automatic logic [3:0] model_cell(input logic [63:0] m, input int i);
        int n;
        int ri;
        int ci;
        int rj;
        int cj;
        n  = 0;
        ri = i / 8;
        ci = i % 8;
`ifdef ADJ_SCAN_MINE_MARK_EN
        if (m[i]) return 4'hF;
`endif
        for (int j = 0; j < 64; j++) begin
            rj = j / 8;
            cj = j % 8;
            if (j != i && (ri - rj) <= 1 && (rj - ri) <= 1 &&
                (ci - cj) <= 1 && (cj - ci) <= 1 && m[j]) n++;
        end
        return 4'(n);
    endfunction

    function automatic int model_total(input logic [63:0] m);
        int n;
        n = 0;
        for (int j = 0; j < 64; j++) if (m[j]) n++;
        return n;
    endfunction

    task automatic run_scan(input logic [63:0] map, input int stall_addr,
                            input int abort_addr, input bit start_with_abort);
        int cyc;
        int stalled;
        bit ended;
        wr_beat_t exp_beat;
        cyc     = 0;
        stalled = 0;
        ended   = 1'b0;
        @(negedge clk);
        mine_map = map;
        start    = 1'b1;
        abort    = start_with_abort;
        wr_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp_beat.addr = 6'(i);
            exp_beat.data = model_cell(map, i);
            sb.push_back(exp_beat);
        end
        @(negedge clk);
        start    = 1'b0;
        abort    = 1'b0;
        mine_map = ~map;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("mine_total", 64'(mine_total), 64'(model_total(map)));
        while (!ended && cyc < 400) begin
            if (done) begin
                chk("done_latency", 64'(cyc), 64'(64 + stalled));
                chk("sb_empty", 64'(sb.size()), 64'd0);
                chk("busy_in_done", 64'(busy), 64'd0);
                @(negedge clk);
                chk("done_one_cycle", 64'(done), 64'd0);
                ended = 1'b1;
            end else if (wr_en) begin
                chk("busy_with_wr_en", 64'(busy), 64'd1);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                    ended = 1'b1;
                end else begin
                    chk("wr_addr", 64'(wr_addr), 64'(sb[0].addr));
                    chk("wr_data", 64'(wr_data), 64'(sb[0].data));
                    if (int'(wr_addr) == 30) start = 1'b1;
                    else if (int'(wr_addr) == 33) start = 1'b0;
                    if (int'(wr_addr) == abort_addr) begin
                        abort    = 1'b1;
                        wr_ready = 1'b1;
                        @(negedge clk);
                        abort = 1'b0;
                        chk("abort_busy", 64'(busy), 64'd0);
                        chk("abort_wr_en", 64'(wr_en), 64'd0);
                        chk("abort_done", 64'(done), 64'd0);
                        sb.delete();
                        repeat (3) begin
                            @(negedge clk);
                            chk("abort_no_done", 64'(done), 64'd0);
                            chk("abort_idle", 64'(busy), 64'd0);
                        end
                        ended = 1'b1;
                    end else begin
                        wr_ready = !(int'(wr_addr) == stall_addr && stalled < 5);
                        if (!wr_ready) stalled++;
                        else void'(sb.pop_front());
                    end
                end
                cyc++;
            end else begin
                chk("wr_en_dropped", 64'(wr_en), 64'd1);
                ended = 1'b1;
            end
            if (!ended) @(negedge clk);
        end
        if (!ended) chk("timeout", 64'(ended), 64'd1);
        start    = 1'b0;
        abort    = 1'b0;
        wr_ready = 1'b1;
        sb.delete();
    endtask

    initial begin
        logic [63:0] rmap;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        wr_ready = 1'b1;
        mine_map = '1;
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_total", 64'(mine_total), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort in IDLE does nothing.
        @(negedge clk);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'd0);

        run_scan(64'h0, -1, -1, 1'b0);
        run_scan('1, -1, -1, 1'b0);
        run_scan(64'h80, -1, -1, 1'b0);
        rmap = {$urandom, $urandom};
        run_scan(rmap, 10, -1, 1'b0);
        rmap = {$urandom, $urandom};
        run_scan(rmap, -1, 20, 1'b0);
        rmap = {$urandom, $urandom};
        run_scan(rmap, -1, -1, 1'b1);

        // Reset mid-scan clears everything without a clock edge.
        @(negedge clk);
        mine_map = '1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        chk("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
        chk("mid_rst_total", 64'(mine_total), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(busy), 64'd0);
            chk("post_rst_wr_en", 64'(wr_en), 64'd0);
        end
        rmap = {$urandom, $urandom};
        run_scan(rmap, 63, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adj_scan.md
ADJ_SCAN -- requirements
Module: adj_scan

Interface
REQ-001 SHALL have parameter ROWS, default 8, board row count (fixed at 8).
REQ-002 SHALL have parameter COLS, default 8, board column count (fixed at 8).
REQ-003 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, scan request, sampled in IDLE.
REQ-006 SHALL have port abort, input, 1, cancels an in-progress scan.
REQ-007 SHALL have port mine_map, input, 64, bit i = 1 means cell i holds a mine.
REQ-008 SHALL have port busy, output, 1, high in SCAN.
REQ-009 SHALL have port done, output, 1, one-cycle pulse after the last cell is accepted.
REQ-010 SHALL have port wr_en, output, 1, result valid.
REQ-011 SHALL have port wr_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port wr_addr, output, 6, cell index of the current result.
REQ-013 SHALL have port wr_data, output, 4, neighbour-mine count for wr_addr.
REQ-014 SHALL have port mine_total, output, 7, total mines in the latched map, range 0..64.

Function
REQ-015 SHALL index cells as idx = row*8 + col, with row = idx[5:3] and col = idx[2:0].
REQ-016 SHALL treat as neighbours the cells at row±1 and col±1 that lie inside 0..7, excluding the cell itself, with no wrap-around: a corner has 3 neighbours, an edge 5, an interior cell 8.
REQ-017 SHALL set wr_data to the population count of (latched map AND neighbour mask of wr_addr); the value is at most 8.
REQ-018 SHALL use states IDLE, SCAN and DONE.
REQ-019 SHALL, in IDLE with start=1, latch mine_map, set the index to 0, compute mine_total as a 7-bit untruncated count, and enter SCAN on the next edge.
REQ-020 SHALL, in SCAN, hold wr_en=1, and drive wr_addr from the index register and wr_data combinationally from the registered index and latched map.
REQ-021 SHALL advance the index only on a cycle where wr_en=1 and wr_ready=1; while wr_ready=0, wr_addr and wr_data SHALL remain stable.
REQ-022 SHALL emit wr_addr values 0..63 in ascending order, each exactly once, with none skipped or repeated.
REQ-023 SHALL go from SCAN to DONE when index 63 is accepted; DONE asserts done for one cycle, then goes to IDLE.
REQ-024 SHALL ignore start while in SCAN or DONE; mine_map changes after the latch SHALL have no effect.
REQ-025 SHALL, on abort=1 in SCAN, go to IDLE on the next edge with wr_en=0 and no done pulse; abort in IDLE or DONE is ignored, and start=1 with abort=1 in IDLE starts a scan.
REQ-026 SHALL, with the consumer always ready, take exactly 64 SCAN cycles plus 1 DONE cycle from the first wr_en to the done pulse.
REQ-027 SHALL hold mine_total from the latch until the next accepted start.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state=IDLE, busy=0, done=0, wr_en=0, wr_addr=0, mine_total=0, and clear the latched map.
REQ-029 SHALL, when reset is asserted mid-scan, discard the scan; the first scan after release requires a fresh start.

Configuration
REQ-030 SHALL, when ADJ_SCAN_MINE_MARK_EN is defined, output wr_data=4'hF for any cell whose own map bit is 1.
REQ-031 SHALL, when ADJ_SCAN_MINE_MARK_EN is undefined, output the neighbour count for every cell, mine or not; timing and handshake SHALL be identical in both builds.

Structure
REQ-032 SHALL take the constants BOARD_CELLS=64, IDX_W=6, CNT_W=4, TOTAL_W=7, MINE_CODE=4'hF and the state enum from the shared minesweeper package.
REQ-033 SHALL place the neighbour mask generation (6-bit index -> 64-bit mask, combinational) in sub-module adj_mask.
REQ-034 SHALL perform all counting with the codebase's 64-bit population-count function.

Verification
REQ-035 SHALL cover: map=0, start, wr_ready=1 -> 64 writes with addr 0..63 and data 0, done 65 cycles after the first wr_en, mine_total=0.
REQ-036 SHALL cover: map=all ones -> data 3 at 0/7/56/63, 5 at other edges, 8 at interior, mine_total=64; with the macro defined -> all 4'hF.
REQ-037 SHALL cover: single mine at idx 7 -> cells 6, 14 and 15 = 1, cell 8 = 0 (no wrap), all others 0; mine_total=1.
REQ-038 SHALL cover: wr_ready=0 for 5 cycles while wr_addr=10 -> wr_addr and wr_data held, then 11 follows with no gap.
REQ-039 SHALL cover: abort while wr_addr=20 -> busy=0 next cycle, no done; a new start rescans from 0 with the new map.
REQ-040 SHALL cover: rst_n low mid-scan -> all outputs 0 immediately without a clock edge; start ignored during SCAN.
